// File: rtl/shiftleft_iter_pkg.sv
// shiftleft_iter_pkg: state encoding and default widths shared by the shifter and the ALU
package shiftleft_iter_pkg;
    localparam int DEF_WIDTH   = 32;
    localparam int DEF_SHAMT_W = 5;
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;
endpackage

// File: rtl/shiftleft_one.sv
// shiftleft_one: combinational left shift by one with zero fill; reports the bit pushed out
module shiftleft_one #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] data_o,
    output logic             msb_o
);
    assign data_o = {data_i[WIDTH-2:0], 1'b0};
    assign msb_o  = data_i[WIDTH-1];
endmodule

// File: rtl/shiftleft_iter.sv
// shiftleft_iter: multicycle logical shift-left, one bit per clock, with lost-significance flag
module shiftleft_iter
    import shiftleft_iter_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int SHAMT_W = DEF_SHAMT_W
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               ctrl_start,
    input  logic [WIDTH-1:0]   data_operand,
    input  logic [SHAMT_W-1:0] shamt,
    output logic [WIDTH-1:0]   data_result,
    output logic               data_resultRDY,
    output logic               data_exception,
    output logic               busy
);
    state_t             state_q, state_d;
    logic [WIDTH-1:0]   reg_q, reg_d, shifted;
    logic [SHAMT_W-1:0] cnt_q, cnt_d;
    logic               exc_q, exc_d, msb, accept, shifting;

    shiftleft_one #(.WIDTH(WIDTH)) u_shift (
        .data_i(reg_q),
        .data_o(shifted),
        .msb_o (msb)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
            reg_q   <= '0;
            cnt_q   <= '0;
            exc_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            reg_q   <= reg_d;
            cnt_q   <= cnt_d;
            exc_q   <= exc_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: state_d = ctrl_start ? ST_BUSY : ST_IDLE;
            ST_BUSY: state_d = (cnt_q == '0) ? ST_DONE : ST_BUSY;
            ST_DONE: state_d = ctrl_start ? ST_BUSY : ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Starts while BUSY are dropped; the decrement is gated so the counter never wraps
    always_comb begin
        accept   = ctrl_start && (state_q != ST_BUSY);
        shifting = (state_q == ST_BUSY) && (cnt_q != '0);
        reg_d    = accept ? data_operand : shifting ? shifted : reg_q;
        cnt_d    = accept ? shamt : shifting ? cnt_q - 1'b1 : cnt_q;
        exc_d    = accept ? 1'b0 : shifting ? (exc_q | msb) : exc_q;
    end

    always_comb begin
        data_result    = reg_q;
        data_exception = exc_q;
        data_resultRDY = (state_q == ST_DONE);
        busy           = (state_q == ST_BUSY);
    end
endmodule

// File: tb/tb_shiftleft_iter.sv
// tb_shiftleft_iter: directed vectors with hand-computed results for shiftleft_iter
module tb_shiftleft_iter;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        ctrl_start = 1'b0;
    logic [31:0] data_operand = '0;
    logic [4:0]  shamt = '0;
    logic [31:0] data_result;
    logic        data_resultRDY, data_exception, busy;
    int          checks = 0;
    int          errors = 0;

    shiftleft_iter dut (
        .clock         (clock),
        .reset         (reset),
        .ctrl_start    (ctrl_start),
        .data_operand  (data_operand),
        .shamt         (shamt),
        .data_result   (data_result),
        .data_resultRDY(data_resultRDY),
        .data_exception(data_exception),
        .busy          (busy)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic [31:0] op, input logic [4:0] sh);
        ctrl_start   = 1'b1;
        data_operand = op;
        shamt        = sh;
    endtask

    // Called with a start already driven; returns at the negedge where RDY is seen
    task automatic wait_result(input string tag, input logic [4:0] sh, input logic [31:0] res,
                               input logic exc, input bit poke);
        int cyc = 0;
        int nbusy = 0;
        do begin
            @(negedge clock);
            cyc++;
            if (busy) nbusy++;
            ctrl_start = poke && cyc == 2;
            if (poke && cyc == 2) begin
                data_operand = 32'hFFFF_FFFF;
                shamt        = 5'd1;
            end
        end while (!data_resultRDY && cyc < 100);
        ctrl_start = 1'b0;
        check({tag, "_lat"}, cyc, sh + 32'd2);
        check({tag, "_busy"}, nbusy, sh + 32'd1);
        check({tag, "_res"}, data_result, res);
        check({tag, "_exc"}, {31'b0, data_exception}, {31'b0, exc});
    endtask

    task automatic run(input string tag, input logic [31:0] op, input logic [4:0] sh,
                       input logic [31:0] res, input logic exc, input bit poke);
        @(negedge clock);
        drive(op, sh);
        wait_result(tag, sh, res, exc, poke);
    endtask

    initial begin
        int rdy_seen;
        repeat (2) @(negedge clock);
        check("rst_res", data_result, 32'h0);
        check("rst_rdy", {31'b0, data_resultRDY}, 32'h0);
        check("rst_exc", {31'b0, data_exception}, 32'h0);
        check("rst_busy", {31'b0, busy}, 32'h0);
        reset = 1'b0;

        run("basic", 32'h0000_0001, 5'd4, 32'h0000_0010, 1'b0, 1'b0);
        @(negedge clock);
        check("pulse_low", {31'b0, data_resultRDY}, 32'h0);
        check("held_res", data_result, 32'h0000_0010);

        run("zero", 32'hDEAD_BEEF, 5'd0, 32'hDEAD_BEEF, 1'b0, 1'b0);
        run("ovf", 32'h8000_0001, 5'd1, 32'h0000_0002, 1'b1, 1'b0);
        run("max", 32'hFFFF_FFFF, 5'd31, 32'h8000_0000, 1'b1, 1'b0);
        run("poke", 32'h0000_0001, 5'd5, 32'h0000_0020, 1'b0, 1'b1);

        drive(32'h0000_0003, 5'd2);
        wait_result("chain", 5'd2, 32'h0000_000C, 1'b0, 1'b0);

        run("nz", 32'h0000_0100, 5'd3, 32'h0000_0800, 1'b0, 1'b0);

        @(negedge clock);
        drive(32'h0000_0FFF, 5'd20);
        @(negedge clock);
        ctrl_start = 1'b0;
        repeat (3) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        check("abort_busy", {31'b0, busy}, 32'h0);
        check("abort_res", data_result, 32'h0);
        check("abort_exc", {31'b0, data_exception}, 32'h0);
        check("abort_rdy", {31'b0, data_resultRDY}, 32'h0);
        rdy_seen = 0;
        repeat (30) begin
            @(negedge clock);
            if (data_resultRDY) rdy_seen++;
        end
        check("abort_norddy", rdy_seen, 32'h0);

        @(negedge clock);
        reset = 1'b1;
        drive(32'h0000_0001, 5'd1);
        @(negedge clock);
        reset = 1'b0;
        ctrl_start = 1'b0;
        check("rst_wins", {31'b0, busy}, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
